// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// the byte-enable mask helper used for both aligned and line-crossing beats.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    RESP   = 3'd5
  } state_t;

  // Enables across two consecutive beats: low nb bits belong to the first
  // beat, the next nb bits to the second (only non-zero on a split access).
  function automatic logic [15:0] be_mask(input logic [1:0] size,
                                          input logic [2:0] off,
                                          input int         nb);
    int nbytes;
    int m;
    nbytes = 1 << size;
    m      = ((1 << nbytes) - 1) << off;
    return 16'(m & ((1 << (2 * nb)) - 1));
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational sign/zero extender: widens a right-justified byte, half or
// word to XLEN; full-width values pass through untouched.
module load_extend
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_data
);

  int   w_bits;
  logic w_sign;

  always_comb begin
    w_bits = XLEN;
    w_sign = 1'b0;
    case (i_size)
      SZ_B:    begin w_bits = 8;    w_sign = i_data[7];      end
      SZ_H:    begin w_bits = 16;   w_sign = i_data[15];     end
      SZ_W:    begin w_bits = 32;   w_sign = i_data[31];     end
      default: begin w_bits = XLEN; w_sign = i_data[XLEN-1]; end
    endcase
    // When w_bits == XLEN the fill bits never apply, so dword (and word at
    // XLEN=32) ignore i_unsigned naturally.
    for (int i = 0; i < XLEN; i++) begin
      o_data[i] = (i < w_bits) ? i_data[i] : (w_sign & ~i_unsigned);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the datapath and a handshaked data memory; one
// access in flight, misaligned accesses split into two beats or faulted.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output state_t            dbg_state
);

  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);
  localparam int BEW   = 2 * NB;

  // Handshake: a request transfers on a clk edge where req_valid && req_ready;
  // a memory beat transfers where mem_req && mem_gnt, and completes on a later
  // mem_rvalid. Every output below is decoded from registered state only.

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_uns;
  logic [ADDR_W-1:0]   r_addr;
  logic [XLEN-1:0]     r_wdata;
  logic                r_split;
  logic                r_fault;
  logic [XLEN-1:0]     r_buf;

  logic [OFS_W-1:0]    w_req_off;
  logic                w_req_split;
  logic                w_req_illegal;
  logic                w_req_fault;

  logic [OFS_W-1:0]    w_off;
  logic [OFS_W+2:0]    w_sh0;
  logic [OFS_W+3:0]    w_sh1;
  logic [BEW-1:0]      w_be_full;
  logic [2*XLEN-1:0]   w_wd_wide;
  logic [ADDR_W-1:0]   w_base0;
  logic [ADDR_W-1:0]   w_base1;
  logic [XLEN-1:0]     w_ext;

  assign w_req_off     = req_addr[OFS_W-1:0];
  assign w_req_split   = (int'(w_req_off) + (1 << req_size)) > NB;
  assign w_req_illegal = (req_size == SZ_D) && (XLEN != 64);
  assign w_req_fault   = w_req_illegal || (w_req_split && (MISALIGN_SPLIT == 0));

  assign w_off     = r_addr[OFS_W-1:0];
  assign w_sh0     = {w_off, 3'b000};
  assign w_sh1     = (OFS_W+4)'(XLEN) - (OFS_W+4)'(w_sh0);
  assign w_be_full = BEW'(be_mask(r_size, 3'(w_off), NB));
  // Upper half of the shifted store data is exactly what the second beat needs.
  assign w_wd_wide = {{XLEN{1'b0}}, r_wdata} << w_sh0;
  assign w_base0   = {r_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign w_base1   = {r_addr[ADDR_W-1:OFS_W] + (ADDR_W-OFS_W)'(1), {OFS_W{1'b0}}};

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_data     (r_buf),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_ext)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_be      = '0;
    mem_wdata   = '0;
    rsp_valid   = 1'b0;
    rsp_fault   = 1'b0;
    rsp_rdata   = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_req_fault ? RESP : ISSUE0;
      end
      ISSUE0: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_base0;
        mem_be    = w_be_full[NB-1:0];
        mem_wdata = w_wd_wide[XLEN-1:0];
        if (mem_gnt) w_state_nxt = WAIT0;
      end
      WAIT0: begin
        if (mem_rvalid) w_state_nxt = r_split ? ISSUE1 : RESP;
      end
      ISSUE1: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_base1;
        mem_be    = w_be_full[BEW-1:NB];
        mem_wdata = w_wd_wide[2*XLEN-1:XLEN];
        if (mem_gnt) w_state_nxt = WAIT1;
      end
      WAIT1: begin
        if (mem_rvalid) w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid   = 1'b1;
        rsp_fault   = r_fault;
        rsp_rdata   = (r_we || r_fault) ? '0 : w_ext;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_split <= 1'b0;
      r_fault <= 1'b0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_split <= w_req_split;
            r_fault <= w_req_fault;
            r_buf   <= '0;
          end
        end
        WAIT0:   if (mem_rvalid) r_buf <= mem_rdata >> w_sh0;
        WAIT1:   if (mem_rvalid) r_buf <= r_buf | (mem_rdata << w_sh1);
        default: ;
      endcase
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (XLEN=32): one split-enabled and one
// fault-on-misalign instance behind a shared driver, byte-level memory model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        a_req_ready, a_rsp_valid, a_rsp_fault, a_mem_req, a_mem_we;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  state_t      a_state;
  logic        b_req_ready, b_rsp_valid, b_rsp_fault, b_mem_req, b_mem_we;
  logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;
  state_t      b_state;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut_split (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .rsp_fault(a_rsp_fault), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
    .mem_gnt(mem_gnt & ~sel), .mem_rvalid(mem_rvalid & ~sel), .mem_rdata(mem_rdata),
    .dbg_state(a_state)
  );

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) dut_fault (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_fault(b_rsp_fault), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
    .mem_gnt(mem_gnt & sel), .mem_rvalid(mem_rvalid & sel), .mem_rdata(mem_rdata),
    .dbg_state(b_state)
  );

  wire         req_ready = sel ? b_req_ready : a_req_ready;
  wire         rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  wire         rsp_fault = sel ? b_rsp_fault : a_rsp_fault;
  wire [31:0]  rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  wire         mem_req   = sel ? b_mem_req   : a_mem_req;
  wire         mem_we    = sel ? b_mem_we    : a_mem_we;
  wire [31:0]  mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  wire [3:0]   mem_be    = sel ? b_mem_be    : a_mem_be;
  wire [31:0]  mem_wdata = sel ? b_mem_wdata : a_mem_wdata;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] last_rdata = '0;
  logic [31:0] obs_addr[2];
  logic [3:0]  obs_be[2];
  logic [31:0] obs_wd[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return a ^ 32'hA5C3_5A3C;
  endfunction

  // Assemble the addressed bytes one at a time from the word image, then extend.
  function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns);
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] w;
    v = '0;
    for (int i = 0; i < (1 << size); i++) begin
      a = addr + 32'(i);
      w = get_word({a[31:2], 2'b00});
      v[8*i +: 8] = w[8*a[1:0] +: 8];
    end
    case (size)
      2'b00:   return uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b01:   return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_fault", rsp_fault, e[32]);
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        last_rdata = rsp_rdata;
      end
    end
  end

  task automatic do_access(input logic s, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr,
                           input logic [31:0] wdata, input int dmax);
    int          n, nbeats, gd, rd;
    logic        split, flt;
    logic [31:0] ba, k, ewd, lmask;
    logic [3:0]  ebe;
    n      = 1 << size;
    split  = (int'(addr[1:0]) + n) > 4;
    flt    = (size == 2'b11) || (split && s);
    nbeats = flt ? 0 : (split ? 2 : 1);
    exp_q.push_back({flt, (flt || we) ? 32'h0 : exp_load(addr, size, uns)});
    @(negedge clk);
    sel = s;
    chk("req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      ba = {addr[31:2], 2'b00} + 32'(4 * b);
      ebe = '0; ewd = '0; lmask = '0;
      for (int j = 0; j < 4; j++) begin
        k = ba + 32'(j) - addr;
        if (k < 32'(n)) begin
          ebe[j] = 1'b1;
          ewd[8*j +: 8] = wdata[8*k[1:0] +: 8];
          lmask[8*j +: 8] = 8'hFF;
        end
      end
      gd = $urandom_range(0, dmax);
      rd = $urandom_range(1, dmax + 1);
      for (int g = 0; g <= gd; g++) begin
        chk("mem_req", mem_req, 1'b1);
        chk("mem_addr", mem_addr, ba);
        chk("mem_be", mem_be, ebe);
        chk("mem_we", mem_we, we);
        if (we) chk("mem_wdata", mem_wdata & lmask, ewd);
        obs_addr[b] = mem_addr; obs_be[b] = mem_be; obs_wd[b] = mem_wdata;
        mem_gnt = (g == gd);
        @(negedge clk);
      end
      mem_gnt = 1'b0;
      for (int r = 1; r <= rd; r++) begin
        chk("wait_no_req", mem_req, 1'b0);
        if (r == rd) begin
          mem_rvalid = 1'b1;
          mem_rdata  = get_word(ba);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
    end
    if (nbeats == 0) chk("fault_no_req", mem_req, 1'b0);
    chk("rsp_valid", rsp_valid, 1'b1);
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 1'b0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", a_req_ready, 1'b1);
    chk("rst_mem_req", a_mem_req, 1'b0);
    chk("rst_mem_be", a_mem_be, 4'h0);
    chk("rst_rsp_valid", a_rsp_valid, 1'b0);
    chk("rst_rsp_rdata", a_rsp_rdata, 32'h0);
    chk("rst_state", a_state, IDLE);
    reset = 1'b1;

    mem_img[32'h100] = 32'hDEADBEEF;
    do_access(0, 0, 2'b10, 0, 32'h100, 32'h0, 0);
    chk("lw_value", last_rdata, 32'hDEADBEEF);
    chk("lw_be", obs_be[0], 4'b1111);

    mem_img[32'h100] = 32'h80AABBCC;
    do_access(0, 0, 2'b00, 0, 32'h103, 32'h0, 0);
    chk("lb_value", last_rdata, 32'hFFFFFF80);
    chk("lb_be", obs_be[0], 4'b1000);
    do_access(0, 0, 2'b00, 1, 32'h103, 32'h0, 0);
    chk("lbu_value", last_rdata, 32'h00000080);

    do_access(0, 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 0);
    chk("sh_be", obs_be[0], 4'b1100);
    chk("sh_wdata", obs_wd[0], 32'hABCD0000);

    mem_img[32'h100] = 32'h44332211;
    mem_img[32'h104] = 32'h88776655;
    do_access(0, 0, 2'b10, 0, 32'h103, 32'h0, 0);
    chk("split_value", last_rdata, 32'h77665544);
    chk("split_addr1", obs_addr[1], 32'h104);
    chk("split_be1", obs_be[1], 4'b0111);
    do_access(0, 1, 2'b10, 0, 32'hFFFFFFFF, 32'hCAFEF00D, 0);
    chk("wrap_addr0", obs_addr[0], 32'hFFFFFFFC);
    chk("wrap_addr1", obs_addr[1], 32'h0);

    do_access(1, 0, 2'b01, 0, 32'h103, 32'h0, 0);
    do_access(0, 0, 2'b11, 0, 32'h100, 32'h0, 0);
    do_access(1, 0, 2'b10, 1, 32'h104, 32'h0, 1);

    // Reset while waiting for the first beat, then a stale completion.
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h200;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("pre_rst_state", a_state, WAIT0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rst_ready", a_req_ready, 1'b1);
    chk("mid_rst_mem_req", a_mem_req, 1'b0);
    chk("mid_rst_state", a_state, IDLE);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (3) begin
      chk("stale_no_rsp", a_rsp_valid, 1'b0);
      @(negedge clk);
    end

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                      : 32'($urandom_range(0, 63));
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, 2);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
